object_spawn_scheduler: RTL and testbench

Shares the collider object pool between the two spawn sources in the game runtime: the attack-pattern reader and the platform reader. It arbitrates their spawn requests round-robin and allocates the lowest-indexed free slot. It then hands the descriptor to that slot's position-control instance through a valid/ready load handshake. It also tracks slot occupancy from per-slot release pulses and exposes the busy map that replaces the ad-hoc `object_ready_state` bookkeeping.

---
 rtl/object_spawn_scheduler.sv | 139 +++++++++++++
 tb/tb_object_spawn_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/object_spawn_scheduler.sv
// Arbitrates attack/platform spawn requests round-robin, allocates the lowest free
// collider slot, delivers the descriptor over a valid/ready load, and tracks occupancy.
module object_spawn_scheduler #(
  parameter int SLOTS  = 30,
  parameter int SLOT_W = 5,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              clk_reset,
  input  logic              stage_clear,
  input  logic              atk_req,
  input  logic [DATA_W-1:0] atk_data,
  output logic              atk_ack,
  input  logic              plt_req,
  input  logic [DATA_W-1:0] plt_data,
  output logic              plt_ack,
  input  logic [SLOTS-1:0]  slot_release,
  output logic              load_valid,
  output logic [SLOT_W-1:0] load_slot,
  output logic [DATA_W-1:0] load_data,
  input  logic              load_ready,
  output logic [SLOTS-1:0]  busy_map,
  output logic [SLOT_W:0]   active_count,
  output logic              pool_full
);

  typedef enum logic {IDLE, LOAD} state_t;
  typedef enum logic {SRC_ATK, SRC_PLT} src_t;

  state_t              state, state_next;
  src_t                last_grant, last_grant_next;
  logic [SLOTS-1:0]    busy_next;
  logic [SLOTS-1:0]    alloc_onehot;
  logic [SLOT_W-1:0]   free_idx;
  logic                grant_atk, grant_plt;
  logic                load_valid_next;
  logic [SLOT_W-1:0]   load_slot_next;
  logic [DATA_W-1:0]   load_data_next;

  function automatic logic [SLOT_W-1:0] lowest_free(input logic [SLOTS-1:0] map);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!map[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [SLOT_W:0] popcount(input logic [SLOTS-1:0] map);
    logic [SLOT_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      cnt = cnt + (SLOT_W+1)'(map[i]);
    end
    return cnt;
  endfunction

  // Free index uses the registered map, so a release only frees capacity next cycle.
  assign free_idx = lowest_free(busy_map);

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant_atk       = 1'b0;
    grant_plt       = 1'b0;
    alloc_onehot    = '0;
    load_valid_next = load_valid;
    load_slot_next  = load_slot;
    load_data_next  = load_data;
    busy_next       = busy_map & ~slot_release;

    if (stage_clear) begin
      state_next      = IDLE;
      load_valid_next = 1'b0;
      busy_next       = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!pool_full) begin
            if (atk_req && plt_req) begin
              grant_atk = (last_grant == SRC_PLT);
              grant_plt = (last_grant == SRC_ATK);
            end else begin
              grant_atk = atk_req;
              grant_plt = plt_req;
            end
          end
          if (grant_atk || grant_plt) begin
            alloc_onehot    = {{(SLOTS-1){1'b0}}, 1'b1} << free_idx;
            busy_next       = busy_next | alloc_onehot;
            load_slot_next  = free_idx;
            load_data_next  = grant_atk ? atk_data : plt_data;
            load_valid_next = 1'b1;
            last_grant_next = grant_atk ? SRC_ATK : SRC_PLT;
            state_next      = LOAD;
          end
        end
        LOAD: begin
          if (load_ready) begin
            load_valid_next = 1'b0;
            state_next      = IDLE;
          end
        end
        default: begin
          state_next      = IDLE;
          load_valid_next = 1'b0;
        end
      endcase
    end
  end

  // Count and full flag are derived from busy_next so they register with the map.
  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      state        <= IDLE;
      last_grant   <= SRC_PLT;
      busy_map     <= '0;
      active_count <= '0;
      pool_full    <= 1'b0;
      atk_ack      <= 1'b0;
      plt_ack      <= 1'b0;
      load_valid   <= 1'b0;
      load_slot    <= '0;
      load_data    <= '0;
    end else begin
      state        <= state_next;
      last_grant   <= last_grant_next;
      busy_map     <= busy_next;
      active_count <= popcount(busy_next);
      pool_full    <= &busy_next;
      atk_ack      <= grant_atk;
      plt_ack      <= grant_plt;
      load_valid   <= load_valid_next;
      load_slot    <= load_slot_next;
      load_data    <= load_data_next;
    end
  end

endmodule

// File: tb/tb_object_spawn_scheduler.sv
// Directed bench for object_spawn_scheduler: a vector table for the single-cycle
// behaviour plus hand-written sequences for arbitration, pool-full stall and flush.
module tb_object_spawn_scheduler;

  localparam int SLOTS  = 30;
  localparam int SLOT_W = 5;
  localparam int DATA_W = 48;
  localparam logic [DATA_W-1:0] DATA_A = 48'h00AB_CD12_3456;
  localparam logic [DATA_W-1:0] DATA_P = 48'h0000_1111_2222;

  logic              clk;
  logic              clk_reset;
  logic              stage_clear;
  logic              atk_req;
  logic [DATA_W-1:0] atk_data;
  logic              atk_ack;
  logic              plt_req;
  logic [DATA_W-1:0] plt_data;
  logic              plt_ack;
  logic [SLOTS-1:0]  slot_release;
  logic              load_valid;
  logic [SLOT_W-1:0] load_slot;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [SLOTS-1:0]  busy_map;
  logic [SLOT_W:0]   active_count;
  logic              pool_full;

  int n_cmp;
  int n_fail;

  object_spawn_scheduler #(.SLOTS(SLOTS), .SLOT_W(SLOT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clk_reset(clk_reset), .stage_clear(stage_clear),
    .atk_req(atk_req), .atk_data(atk_data), .atk_ack(atk_ack),
    .plt_req(plt_req), .plt_data(plt_data), .plt_ack(plt_ack),
    .slot_release(slot_release),
    .load_valid(load_valid), .load_slot(load_slot), .load_data(load_data),
    .load_ready(load_ready),
    .busy_map(busy_map), .active_count(active_count), .pool_full(pool_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              a, p, r, c;
    logic [SLOTS-1:0]  rel;
    logic              e_aack, e_pack, e_lv;
    logic [SLOT_W-1:0] e_slot;
    logic [SLOTS-1:0]  e_busy;
    logic [SLOT_W:0]   e_cnt;
    logic              e_dp;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clk_reset    = 1'b0;
    stage_clear  = 1'b0;
    atk_req      = 1'b0;
    plt_req      = 1'b0;
    slot_release = '0;
    load_ready   = 1'b0;
    step();
    step();
    clk_reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic a, p, r, c, input logic [SLOTS-1:0] rel,
                              input logic ea, ep, ev, input logic [SLOT_W-1:0] es,
                              input logic [SLOTS-1:0] eb, input logic [SLOT_W:0] ec,
                              input logic ed);
    vec_t v;
    v.a = a; v.p = p; v.r = r; v.c = c; v.rel = rel;
    v.e_aack = ea; v.e_pack = ep; v.e_lv = ev; v.e_slot = es;
    v.e_busy = eb; v.e_cnt = ec; v.e_dp = ed;
    return v;
  endfunction

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    atk_data = DATA_A;
    plt_data = DATA_P;

    //            a     p     r     c     rel       aack  pack  lv    slot   busy      cnt    dp
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 30'h0, 1'b1, 1'b0, 1'b1, 5'd0, 30'h01, 6'd1, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 5'd0, 30'h01, 6'd1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 5'd1, 30'h03, 6'd2, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 5'd1, 30'h03, 6'd2, 1'b1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 5'd2, 30'h07, 6'd3, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h2, 1'b0, 1'b0, 1'b0, 5'd2, 30'h05, 6'd2, 1'b1);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b0, 1'b1, 5'd1, 30'h07, 6'd3, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b1, 5'd1, 30'h07, 6'd3, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b1, 5'd1, 30'h07, 6'd3, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b1, 5'd1, 30'h07, 6'd3, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b1, 5'd1, 30'h07, 6'd3, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b1, 5'd1, 30'h07, 6'd3, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 5'd1, 30'h07, 6'd3, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 5'd3, 30'h0F, 6'd4, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 5'd3, 30'h0F, 6'd4, 1'b1);
    tbl[15] = mk(1'b1, 1'b0, 1'b1, 1'b0, 30'h8, 1'b1, 1'b0, 1'b1, 5'd4, 30'h17, 6'd4, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 5'd4, 30'h17, 6'd4, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h8, 1'b0, 1'b0, 1'b0, 5'd4, 30'h17, 6'd4, 1'b0);
    tbl[18] = mk(1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 5'd3, 30'h1F, 6'd5, 1'b1);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 30'h8, 1'b0, 1'b0, 1'b1, 5'd3, 30'h17, 6'd4, 1'b1);
    tbl[20] = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 5'd3, 30'h17, 6'd4, 1'b1);
    tbl[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b0, 1'b1, 5'd3, 30'h1F, 6'd5, 1'b0);
    tbl[22] = mk(1'b0, 1'b1, 1'b0, 1'b1, 30'h0, 1'b0, 1'b0, 1'b0, 5'd3, 30'h00, 6'd0, 1'b0);
    tbl[23] = mk(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 5'd0, 30'h01, 6'd1, 1'b1);
    tbl[24] = mk(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 5'd0, 30'h01, 6'd1, 1'b1);

    // Reset values
    do_reset();
    chk("rst_load_valid", 64'(load_valid), 64'(0));
    chk("rst_busy_map", 64'(busy_map), 64'(0));
    chk("rst_active_count", 64'(active_count), 64'(0));
    chk("rst_pool_full", 64'(pool_full), 64'(0));
    chk("rst_atk_ack", 64'(atk_ack), 64'(0));
    chk("rst_plt_ack", 64'(plt_ack), 64'(0));
    chk("rst_load_slot", 64'(load_slot), 64'(0));
    chk("rst_load_data", 64'(load_data), 64'(0));

    // Vector table
    for (int i = 0; i < 25; i++) begin
      atk_req      = tbl[i].a;
      plt_req      = tbl[i].p;
      load_ready   = tbl[i].r;
      stage_clear  = tbl[i].c;
      slot_release = tbl[i].rel;
      step();
      chk($sformatf("v%0d_atk_ack", i), 64'(atk_ack), 64'(tbl[i].e_aack));
      chk($sformatf("v%0d_plt_ack", i), 64'(plt_ack), 64'(tbl[i].e_pack));
      chk($sformatf("v%0d_load_valid", i), 64'(load_valid), 64'(tbl[i].e_lv));
      chk($sformatf("v%0d_load_slot", i), 64'(load_slot), 64'(tbl[i].e_slot));
      chk($sformatf("v%0d_busy_map", i), 64'(busy_map), 64'(tbl[i].e_busy));
      chk($sformatf("v%0d_active_count", i), 64'(active_count), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_pool_full", i), 64'(pool_full), 64'(0));
      if (tbl[i].e_lv)
        chk($sformatf("v%0d_load_data", i), 64'(load_data),
            64'(tbl[i].e_dp ? DATA_P : DATA_A));
    end
    stage_clear  = 1'b0;
    slot_release = '0;

    // Both sources held: alternating grants fill the pool in index order
    do_reset();
    atk_req    = 1'b1;
    plt_req    = 1'b1;
    load_ready = 1'b1;
    for (int g = 0; g < SLOTS; g++) begin
      step();
      chk($sformatf("alt%0d_atk_ack", g), 64'(atk_ack), 64'((g % 2) == 0));
      chk($sformatf("alt%0d_plt_ack", g), 64'(plt_ack), 64'((g % 2) == 1));
      chk($sformatf("alt%0d_load_slot", g), 64'(load_slot), 64'(g));
      chk($sformatf("alt%0d_load_data", g), 64'(load_data),
          64'(((g % 2) == 0) ? DATA_A : DATA_P));
      step();
      chk($sformatf("alt%0d_gap_valid", g), 64'(load_valid), 64'(0));
      if (g == 7) chk("alt_busy_after8", 64'(busy_map), 64'(30'hFF));
    end
    chk("full_pool_full", 64'(pool_full), 64'(1));
    chk("full_active_count", 64'(active_count), 64'(30));
    atk_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("full_stall%0d_plt_ack", k), 64'(plt_ack), 64'(0));
      chk($sformatf("full_stall%0d_load_valid", k), 64'(load_valid), 64'(0));
    end
    slot_release = 30'h1 << 17;
    step();
    slot_release = '0;
    chk("rel17_busy_bit", 64'(busy_map[17]), 64'(0));
    chk("rel17_active_count", 64'(active_count), 64'(29));
    chk("rel17_pool_full", 64'(pool_full), 64'(0));
    chk("rel17_no_ack_same_cycle", 64'(plt_ack), 64'(0));
    step();
    plt_req = 1'b0;
    chk("refill_plt_ack", 64'(plt_ack), 64'(1));
    chk("refill_load_slot", 64'(load_slot), 64'(17));
    chk("refill_active_count", 64'(active_count), 64'(30));
    chk("refill_pool_full", 64'(pool_full), 64'(1));

    // Flush during LOAD with ten slots busy, then async reset mid-LOAD
    do_reset();
    atk_req    = 1'b1;
    load_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      step();
      chk($sformatf("clr_fill%0d_atk_ack", g), 64'(atk_ack), 64'(1));
      chk($sformatf("clr_fill%0d_load_slot", g), 64'(load_slot), 64'(g));
      if (g < 9) step();
    end
    load_ready = 1'b0;
    chk("clr_busy_before", 64'(busy_map), 64'(30'h3FF));
    step();
    chk("clr_still_loading", 64'(load_valid), 64'(1));
    chk("clr_no_ack_in_load", 64'(atk_ack), 64'(0));
    stage_clear = 1'b1;
    step();
    stage_clear = 1'b0;
    chk("clr_busy_map", 64'(busy_map), 64'(0));
    chk("clr_load_valid", 64'(load_valid), 64'(0));
    chk("clr_atk_ack", 64'(atk_ack), 64'(0));
    chk("clr_active_count", 64'(active_count), 64'(0));
    step();
    chk("after_clr_atk_ack", 64'(atk_ack), 64'(1));
    chk("after_clr_load_slot", 64'(load_slot), 64'(0));
    chk("after_clr_busy_map", 64'(busy_map), 64'(30'h1));
    #2;
    clk_reset = 1'b0;
    #1;
    chk("async_rst_load_valid", 64'(load_valid), 64'(0));
    chk("async_rst_busy_map", 64'(busy_map), 64'(0));
    chk("async_rst_atk_ack", 64'(atk_ack), 64'(0));
    chk("async_rst_load_data", 64'(load_data), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
